// File: rtl/key_event_instruction_injector_pkg.sv
// Shared types for the key event instruction injector: addi encoding and instruction layout.
package key_event_instruction_injector_pkg;

    localparam logic [4:0] OPC_ADDI = 5'd5;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned IMM_W   = 17;

    // Field positions: opcode [31:27], rd [26:22], rs [21:17], imm [16:0]
    typedef struct packed {
        logic [4:0]       opcode;
        logic [4:0]       rd;
        logic [4:0]       rs;
        logic [IMM_W-1:0] imm;
    } instr_t;

    function automatic instr_t make_addi(input logic [4:0] rd, input logic imm_bit);
        instr_t w;
        w.opcode = OPC_ADDI;
        w.rd     = rd;
        w.rs     = REG_ZERO;
        w.imm    = IMM_W'(imm_bit);
        return w;
    endfunction

endpackage

// File: rtl/key_event_instruction_injector_if.sv
// Valid/ready instruction offer from the injector to the CPU fetch path.
interface key_event_instruction_injector_if;
    import key_event_instruction_injector_pkg::*;

    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] instruction;

    modport master (output inst_valid, output instruction, input inst_ready);
    modport slave  (input inst_valid, input instruction, output inst_ready);
endinterface

// File: rtl/key_event_instruction_injector_key_debouncer.sv
// One key channel: 2-flop synchroniser, stability counter, debounced level and edge pulses.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic key_state,
    output logic press_c,
    output logic release_c
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             flip_c;

    // Level accepted once it has differed from the debounced value DEBOUNCE_CYCLES samples in a row
    assign flip_c    = (sync2_q != deb_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press_c   = flip_c && !deb_q;
    assign release_c = flip_c && deb_q;
    assign key_state = deb_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (flip_c) begin
                deb_q <= ~deb_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/key_event_instruction_injector.sv
// Key events to addi injections with per-key pending state and round-robin arbitration.
// Optional feature macro: KEY_RELEASE_EN (release edges inject an immediate-0 addi).
module key_event_instruction_injector
    import key_event_instruction_injector_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned BASE_REG        = 26,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_KEYS-1:0]    key_raw,
    key_event_instruction_injector_if.master inst_if,
    output logic [NUM_KEYS-1:0]    key_state,
    output logic [15:0]            coalesced_count
);
    localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
`ifdef KEY_RELEASE_EN
    localparam logic RELEASE_EN = 1'b1;
`else
    localparam logic RELEASE_EN = 1'b0;
`endif

    if (NUM_KEYS < 1 || NUM_KEYS > 8) begin : g_bad_num_keys
        $error("NUM_KEYS must be in 1..8");
    end
    if (BASE_REG + NUM_KEYS - 1 > 31) begin : g_bad_base_reg
        $error("BASE_REG+NUM_KEYS-1 exceeds register 31");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [NUM_KEYS-1:0] press_c;
    logic [NUM_KEYS-1:0] release_c;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clock     (clock),
            .reset     (reset),
            .key_raw   (key_raw[g]),
            .key_state (key_state[g]),
            .press_c   (press_c[g]),
            .release_c (release_c[g])
        );
    end

    logic [NUM_KEYS-1:0] pending_q, pending_n;
    logic [NUM_KEYS-1:0] pend_val_q, pend_val_n;
    logic [IDX_W-1:0]    rr_q, rr_n;
    logic                valid_q, valid_n;
    instr_t              instr_q, instr_n;
    logic [15:0]         coal_q, coal_n;

    logic                load_ok;
    logic                found;
    logic                grant;
    logic [IDX_W-1:0]    gidx;
    logic [IDX_W-1:0]    cand;
    logic [3:0]          n_coal;
    logic [16:0]         coal_sum;

    always_comb begin
        load_ok    = !valid_q || inst_if.inst_ready;
        found      = 1'b0;
        gidx       = '0;
        cand       = '0;
        pending_n  = pending_q;
        pend_val_n = pend_val_q;
        n_coal     = '0;
        valid_n    = valid_q;
        instr_n    = instr_q;
        rr_n       = rr_q;

        // First pending key at or after rr_q+1, wrapping
        for (int k = 1; k <= int'(NUM_KEYS); k++) begin
            cand = IDX_W'((32'(rr_q) + 32'(k)) % NUM_KEYS);
            if (!found && pending_q[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        grant = load_ok && found;

        if (grant) begin
            pending_n[gidx] = 1'b0;
        end

        // A new edge always wins over the grant clear; only overwrites of ungranted entries count
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (press_c[i] || (release_c[i] && RELEASE_EN)) begin
                if (pending_q[i] && !(grant && gidx == IDX_W'(i))) begin
                    n_coal = n_coal + 4'd1;
                end
                pending_n[i]  = 1'b1;
                pend_val_n[i] = press_c[i];
            end
        end

        if (load_ok) begin
            valid_n = found;
            if (found) begin
                instr_n = make_addi(5'(BASE_REG + 32'(gidx)), pend_val_q[gidx]);
                rr_n    = gidx;
            end
        end

        coal_sum = 17'(coal_q) + 17'(n_coal);
        coal_n   = coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q  <= '0;
            pend_val_q <= '0;
            rr_q       <= IDX_W'(NUM_KEYS - 1);
            valid_q    <= 1'b0;
            instr_q    <= '0;
            coal_q     <= '0;
        end else begin
            pending_q  <= pending_n;
            pend_val_q <= pend_val_n;
            rr_q       <= rr_n;
            valid_q    <= valid_n;
            instr_q    <= instr_n;
            coal_q     <= coal_n;
        end
    end

    assign inst_if.inst_valid  = valid_q;
    assign inst_if.instruction = instr_q;
    assign coalesced_count     = coal_q;
endmodule
